// File: rtl/dmem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter
// Description : Two-requester data-memory arbiter with burst-limited fairness,
//               store alignment checking and registered load responses.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
  parameter int MAX_BURST = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        r0_req,
  input  logic [1:0]  r0_we,
  input  logic [31:0] r0_addr,
  input  logic [31:0] r0_wdata,
  output logic        r0_gnt,
  output logic        r0_rvalid,
  output logic [31:0] r0_rdata,
  output logic        r0_err,
  input  logic        r1_req,
  input  logic [1:0]  r1_we,
  input  logic [31:0] r1_addr,
  input  logic [31:0] r1_wdata,
  output logic        r1_gnt,
  output logic        r1_rvalid,
  output logic [31:0] r1_rdata,
  output logic        r1_err,
  output logic [1:0]  m_we,
  output logic [31:0] m_a,
  output logic [31:0] m_wd,
  input  logic [31:0] m_rd
);

  localparam int            CW      = $clog2(MAX_BURST) + 1;
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BURST);
  localparam logic [1:0]    OP_LW   = 2'b00;
  localparam logic [1:0]    OP_SW   = 2'b01;
  localparam logic [1:0]    OP_SH   = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD0 = 2'd1,
    HOLD1 = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] burst_cnt, burst_cnt_nxt, cnt_inc;
  logic          gnt0, gnt1, any_gnt, misaligned;
  logic [1:0]    sel_we;
  logic [31:0]   sel_addr, sel_wdata;
  logic [31:0]   hold_a, hold_wd;
  logic          resp_valid, resp_owner, resp_err;
  logic [31:0]   rdata0_q, rdata1_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      burst_cnt <= '0;
    end else begin
      state     <= state_nxt;
      burst_cnt <= burst_cnt_nxt;
    end
  end

  // Grants are masked while reset is high so nothing reaches memory.
  always_comb begin
    gnt0          = 1'b0;
    gnt1          = 1'b0;
    state_nxt     = state;
    burst_cnt_nxt = burst_cnt;
    cnt_inc       = '0;
    if (!reset) begin
      if (r0_req && r1_req) begin
        case (state)
          HOLD0:   if (burst_cnt < MAX_CNT) gnt0 = 1'b1; else gnt1 = 1'b1;
          HOLD1:   if (burst_cnt < MAX_CNT) gnt1 = 1'b1; else gnt0 = 1'b1;
          default: gnt0 = 1'b1;
        endcase
      end else begin
        gnt0 = r0_req;
        gnt1 = r1_req;
      end
    end
    // On the last allowed grant of a contested burst, hand ownership over
    // with a zero count so the new holder gets a full burst.
    if (gnt0) begin
      cnt_inc = (state != HOLD0) ? CW'(1) :
                (burst_cnt >= MAX_CNT) ? MAX_CNT : burst_cnt + CW'(1);
      if (r1_req && (cnt_inc == MAX_CNT)) begin
        state_nxt     = HOLD1;
        burst_cnt_nxt = '0;
      end else begin
        state_nxt     = HOLD0;
        burst_cnt_nxt = cnt_inc;
      end
    end else if (gnt1) begin
      cnt_inc = (state != HOLD1) ? CW'(1) :
                (burst_cnt >= MAX_CNT) ? MAX_CNT : burst_cnt + CW'(1);
      if (r0_req && (cnt_inc == MAX_CNT)) begin
        state_nxt     = HOLD0;
        burst_cnt_nxt = '0;
      end else begin
        state_nxt     = HOLD1;
        burst_cnt_nxt = cnt_inc;
      end
    end else if (!r0_req && !r1_req) begin
      burst_cnt_nxt = '0;
    end
  end

  always_comb begin
    any_gnt    = gnt0 | gnt1;
    sel_we     = gnt1 ? r1_we    : r0_we;
    sel_addr   = gnt1 ? r1_addr  : r0_addr;
    sel_wdata  = gnt1 ? r1_wdata : r0_wdata;
    misaligned = ((sel_we == OP_SW) && (sel_addr[1:0] != 2'b00)) ||
                 ((sel_we == OP_SH) && sel_addr[0]);
    m_we       = (any_gnt && !misaligned) ? sel_we : OP_LW;
    m_a        = any_gnt ? sel_addr  : hold_a;
    m_wd       = any_gnt ? sel_wdata : hold_wd;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_a     <= '0;
      hold_wd    <= '0;
      resp_valid <= 1'b0;
      resp_owner <= 1'b0;
      resp_err   <= 1'b0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
    end else begin
      resp_valid <= any_gnt;
      resp_owner <= gnt1;
      resp_err   <= any_gnt & misaligned;
      if (any_gnt) begin
        hold_a  <= sel_addr;
        hold_wd <= sel_wdata;
      end
      if (gnt0 && (r0_we == OP_LW)) rdata0_q <= m_rd;
      if (gnt1 && (r1_we == OP_LW)) rdata1_q <= m_rd;
    end
  end

  assign r0_gnt    = gnt0;
  assign r1_gnt    = gnt1;
  assign r0_rvalid = resp_valid & ~resp_owner;
  assign r1_rvalid = resp_valid &  resp_owner;
  assign r0_err    = r0_rvalid & resp_err;
  assign r1_err    = r1_rvalid & resp_err;
  assign r0_rdata  = rdata0_q;
  assign r1_rdata  = rdata1_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_dmem_arbiter
// Description : Scoreboard bench for dmem_arbiter with a small word memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

  localparam logic [1:0] LW = 2'b00, SW = 2'b01, SH = 2'b10, SB = 2'b11;

  logic        clk = 1'b0;
  logic        reset;
  logic        r0_req, r1_req;
  logic [1:0]  r0_we, r1_we;
  logic [31:0] r0_addr, r1_addr, r0_wdata, r1_wdata;
  logic        r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, r0_err, r1_err;
  logic [31:0] r0_rdata, r1_rdata;
  logic [1:0]  m_we;
  logic [31:0] m_a, m_wd, m_rd;

  always #5 clk = ~clk;

  dmem_arbiter #(.MAX_BURST(4)) dut (
    .clk(clk), .reset(reset),
    .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata), .r0_err(r0_err),
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata), .r1_err(r1_err),
    .m_we(m_we), .m_a(m_a), .m_wd(m_wd), .m_rd(m_rd)
  );

  // Data memory: combinational read, write latched mid-cycle and applied on the edge.
  logic [31:0] mem [64];
  logic [1:0]  pend_we;
  logic [31:0] pend_a, pend_wd;
  assign m_rd = mem[m_a[7:2]];

  always @(negedge clk) begin
    pend_we <= m_we;
    pend_a  <= m_a;
    pend_wd <= m_wd;
  end

  always @(posedge clk) begin
    if (!reset) begin
      case (pend_we)
        SW: mem[pend_a[7:2]] <= pend_wd;
        SH: if (pend_a[1]) mem[pend_a[7:2]][31:16] <= pend_wd[15:0];
            else           mem[pend_a[7:2]][15:0]  <= pend_wd[15:0];
        SB: mem[pend_a[7:2]][8*pend_a[1:0] +: 8] <= pend_wd[7:0];
        default: ;
      endcase
    end
  end

  typedef struct packed { logic [1:0] g; logic [1:0] we; logic [31:0] a; logic [31:0] wd; } cyc_t;
  typedef struct packed { logic owner; logic err; logic [31:0] rd; } rsp_t;

  cyc_t        cq[$];
  rsp_t        rq[$];
  int          tests = 0;
  int          fails = 0;
  logic        no_rsp = 1'b0;
  logic [31:0] rd0 = '0, rd1 = '0, last_a = '0, last_wd = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_r0_gnt"},    {31'b0, r0_gnt},    32'h0);
    check({tag, "_r1_gnt"},    {31'b0, r1_gnt},    32'h0);
    check({tag, "_r0_rvalid"}, {31'b0, r0_rvalid}, 32'h0);
    check({tag, "_r1_rvalid"}, {31'b0, r1_rvalid}, 32'h0);
    check({tag, "_r0_err"},    {31'b0, r0_err},    32'h0);
    check({tag, "_r1_err"},    {31'b0, r1_err},    32'h0);
    check({tag, "_r0_rdata"},  r0_rdata,           32'h0);
    check({tag, "_r1_rdata"},  r1_rdata,           32'h0);
    check({tag, "_m_we"},      {30'b0, m_we},      32'h0);
    check({tag, "_m_a"},       m_a,                32'h0);
    check({tag, "_m_wd"},      m_wd,               32'h0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Apply one cycle of requests and queue the hand-computed expectations.
  task automatic drive_now(
    input logic q0, input logic [1:0] we0, input logic [31:0] a0, input logic [31:0] wd0,
    input logic q1, input logic [1:0] we1, input logic [31:0] a1, input logic [31:0] wd1,
    input logic [1:0] eg, input logic [1:0] ewe, input logic eerr, input logic [31:0] erd);
    cyc_t c;
    rsp_t r;
    r0_req = q0; r0_we = we0; r0_addr = a0; r0_wdata = wd0;
    r1_req = q1; r1_we = we1; r1_addr = a1; r1_wdata = wd1;
    if (eg == 2'b01) begin last_a = a0; last_wd = wd0; end
    else if (eg == 2'b10) begin last_a = a1; last_wd = wd1; end
    c.g = eg; c.we = ewe; c.a = last_a; c.wd = last_wd;
    cq.push_back(c);
    if (eg != 2'b00 && !no_rsp) begin
      if (eg[1] && we1 == LW) rd1 = erd;
      if (eg[0] && we0 == LW) rd0 = erd;
      r.owner = eg[1];
      r.err   = eerr;
      r.rd    = eg[1] ? rd1 : rd0;
      rq.push_back(r);
    end
  endtask

  task automatic both(input logic [1:0] eg);
    drive_now(1'b1, LW, 32'h40, 32'hA0, 1'b1, LW, 32'h80, 32'hB1,
              eg, LW, 1'b0, eg[1] ? 32'hC0DE0020 : 32'hC0DE0010);
  endtask

  task automatic idle();
    drive_now(1'b0, LW, 32'h0, 32'h0, 1'b0, LW, 32'h0, 32'h0, 2'b00, LW, 1'b0, 32'h0);
  endtask

  task automatic clear_expect();
    rd0 = '0; rd1 = '0; last_a = '0; last_wd = '0;
  endtask

  // Monitor: compare every queued cycle and every presented response.
  always @(negedge clk) begin
    cyc_t c;
    rsp_t r;
    if (r0_rvalid || r1_rvalid) begin
      if (rq.size() == 0) begin
        check("rsp_unexpected", {30'b0, r1_rvalid, r0_rvalid}, 32'h0);
      end else begin
        r = rq.pop_front();
        check("rsp_owner", {30'b0, r1_rvalid, r0_rvalid}, r.owner ? 32'h2 : 32'h1);
        check("rsp_err",   {31'b0, r.owner ? r1_err : r0_err}, {31'b0, r.err});
        check("rsp_rdata", r.owner ? r1_rdata : r0_rdata, r.rd);
      end
    end
    if (cq.size() != 0) begin
      c = cq.pop_front();
      check("gnt",  {30'b0, r1_gnt, r0_gnt}, {30'b0, c.g});
      check("m_we", {30'b0, m_we}, {30'b0, c.we});
      check("m_a",  m_a,  c.a);
      check("m_wd", m_wd, c.wd);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    r0_req = 1'b0; r0_we = LW; r0_addr = '0; r0_wdata = '0;
    r1_req = 1'b0; r1_we = LW; r1_addr = '0; r1_wdata = '0;
    for (int i = 0; i < 64; i++) mem[i] = 32'hC0DE0000 | 32'(i);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    @(posedge clk); #1 reset = 1'b0;

    // Store then load, halfword store, then reload
    tick(); drive_now(1, SW, 32'h10, 32'hDEADBEEF, 0, LW, 0, 0, 2'b01, SW, 0, 0);
    tick(); drive_now(1, LW, 32'h10, 32'h0,        0, LW, 0, 0, 2'b01, LW, 0, 32'hDEADBEEF);
    tick(); drive_now(1, SH, 32'h12, 32'h1234,     0, LW, 0, 0, 2'b01, SH, 0, 0);
    tick(); drive_now(1, LW, 32'h10, 32'h0,        0, LW, 0, 0, 2'b01, LW, 0, 32'h1234BEEF);

    // Misaligned stores from r1 are granted but never written
    tick(); drive_now(0, LW, 0, 0, 1, SH, 32'h13, 32'h5555, 2'b10, LW, 1, 0);
    tick(); drive_now(0, LW, 0, 0, 1, SW, 32'h22, 32'h7777, 2'b10, LW, 1, 0);
    tick(); drive_now(0, LW, 0, 0, 1, LW, 32'h10, 32'h0,    2'b10, LW, 0, 32'h1234BEEF);

    // Byte store at an odd address, reload, then an idle cycle holding m_a/m_wd
    tick(); drive_now(1, SB, 32'h21, 32'hAB, 0, LW, 0, 0, 2'b01, SB, 0, 0);
    tick(); drive_now(1, LW, 32'h20, 32'h0,  0, LW, 0, 0, 2'b01, LW, 0, 32'hC0DEAB08);
    tick(); idle();
    check("mem_word_10", mem[4], 32'h1234BEEF);
    check("mem_word_20", mem[8], 32'hC0DEAB08);

    // Return to IDLE, then contested bursts
    @(negedge clk); #1 reset = 1'b1; clear_expect();
    @(posedge clk); #1 reset = 1'b0;
    both(2'b01);
    repeat (3) begin tick(); both(2'b01); end
    repeat (4) begin tick(); both(2'b10); end
    repeat (2) begin tick(); both(2'b01); end

    // Reset lands mid-burst: the grant of that cycle yields no response
    tick(); no_rsp = 1'b1; both(2'b01); no_rsp = 1'b0;
    @(negedge clk); #1 reset = 1'b1; clear_expect();
    #1 check_zero("midrst");
    @(posedge clk); #1 reset = 1'b0;
    both(2'b01);
    repeat (3) begin tick(); both(2'b01); end
    repeat (4) begin tick(); both(2'b10); end
    tick(); both(2'b01);

    // Idle gap inside an r1 burst restarts its full burst
    repeat (3) begin tick(); both(2'b01); end
    repeat (2) begin tick(); both(2'b10); end
    tick(); idle();
    repeat (4) begin tick(); both(2'b10); end
    tick(); both(2'b01);
    tick(); idle();

    repeat (3) @(negedge clk);
    check("rsp_left", rq.size(), 32'h0);
    check("cyc_left", cq.size(), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
